sev_scan_monitor: RTL and testbench
===================================

SEV_SCAN_MONITOR -- requirements
Module: sev_scan_monitor

Interface
REQ-001 The block SHALL provide parameter SETTLE, default 2: cycles sev_sel must hold one value before capture (range 1..15).
REQ-002 The block SHALL provide parameter STALL_CYCLES, default 1024: cycles with no sev_sel change before stall asserts (range 2..65535).
REQ-003 The block SHALL have ports, in this order:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sev_sel  input  5  digit select, one-hot active-high; bit i selects digit i.
- sev_data  input  8  bit 7 = decimal point; bits 6:0 = segments g..a; active-high.
- digits  output  20  decoded digit i in bits 4i+3:4i.
- dp  output  5  captured decimal point per digit.
- digit_valid  output  5  digit i captured at least once since reset.
- frame_done  output  1  one-cycle pulse when all five digits have been captured since the previous pulse.
- frame_count  output  8  frame_done count, wraps 255 -> 0.
- sel_error  output  1  sticky; sev_sel was non-zero and not one-hot.
- seg_error  output  1  sticky; a captured pattern did not decode.
- stall  output  1  sev_sel unchanged for STALL_CYCLES cycles.

Function
REQ-004 The block SHALL run FSM states IDLE, SETTLE and HOLD.
REQ-005 IDLE SHALL move to SETTLE when sev_sel is one-hot, and load the settle counter with 1.
REQ-006 SETTLE SHALL increment the settle counter each cycle sev_sel equals the registered previous value, and return to IDLE when it differs.
REQ-007 When the settle counter reaches SETTLE, the block SHALL capture sev_data into digit i, set digit_valid[i] and the seen-mask bit i, and move to HOLD. Latency: SETTLE+1 cycles from sev_sel change to updated digits.
REQ-008 HOLD SHALL return to IDLE on any sev_sel change, with no re-capture while sev_sel stays constant.
REQ-009 The block SHALL decode sev_data[6:0] as follows, all other values giving code 0xF and setting seg_error:
- 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4
- 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9
- 0x00->0xA (blank)
REQ-010 sev_data[7] SHALL be stored in dp[i] independently of the decode result.
REQ-011 sev_sel = 0 SHALL be treated as blanking: FSM to IDLE, no error.
REQ-012 A non-one-hot non-zero sev_sel SHALL set sel_error, force the FSM to IDLE, and cause no capture.
REQ-013 When a capture completes the seen-mask (all five bits set), the block SHALL pulse frame_done on the next cycle, clear the seen-mask in that same cycle, and increment frame_count.
REQ-014 Repeated capture of an already-seen digit SHALL update digits and dp without changing the seen-mask.
REQ-015 The stall counter SHALL:
- reset to 0 on any sev_sel change;
- saturate at STALL_CYCLES;
- drive stall high while saturated;
- deassert stall the cycle after sev_sel changes.
REQ-016 sel_error and seg_error SHALL clear only on reset.

Reset
REQ-017 Asserting rst SHALL set, immediately:
- FSM to IDLE;
- digits to 0xAAAAA;
- dp, digit_valid, seen-mask, frame_done, frame_count, sel_error, seg_error, stall, settle counter and stall counter to 0.
REQ-018 Reset asserted mid-SETTLE SHALL discard the pending capture.
REQ-019 After rst deasserts, operation SHALL start on the first rising edge.

Configuration
REQ-020 With SEV_SCAN_MON_FRAMECNT_EN defined, frame_count SHALL behave per REQ-013.
REQ-021 Without SEV_SCAN_MON_FRAMECNT_EN, frame_count SHALL be constant 0, no counter register SHALL exist, and frame_done SHALL be unchanged.

Verification
REQ-022 Reset, then sev_sel=00001 with sev_data=0x06 for 4 cycles -> digits[3:0]=1 at cycle 3, digit_valid=00001, no errors.
REQ-023 Scan digits 0..4 with 0x3F, 0x5B, 0x4F, 0x66, 0xED (4 cycles each) -> digits=0x54320, dp=10000, exactly one frame_done pulse, frame_count=1.
REQ-024 sev_sel=00100 held 1 cycle with SETTLE=2 -> no capture, digit_valid unchanged.
REQ-025 sev_sel=00110 -> sel_error=1 and stays 1; sev_data=0x49 captured on digit 1 -> digits[7:4]=0xF, seg_error=1.
REQ-026 sev_sel constant for 1024 cycles -> stall=1 on cycle 1024; stall=0 the cycle after sev_sel changes.
REQ-027 rst pulsed mid-frame after 3 captures -> all outputs at reset values; a following full frame gives frame_count=1.

Source files
------------

// File: rtl/sev_scan_monitor.sv
// Seven-segment scan monitor: captures multiplexed digits, flags select/segment errors, counts frames, detects a stalled scan.
// Capture latency SETTLE+1 cycles from a select change; pure observer with no backpressure. Frame counter built only with SEV_SCAN_MON_FRAMECNT_EN.
module sev_scan_monitor #(
  parameter int unsigned SETTLE       = 2,
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sev_sel,
  input  logic [7:0]  sev_data,
  output logic [19:0] digits,
  output logic [4:0]  dp,
  output logic [4:0]  digit_valid,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        sel_error,
  output logic        seg_error,
  output logic        stall
);

  localparam int unsigned STW = $clog2(STALL_CYCLES + 1);
  localparam logic [3:0]     SETTLE_L = 4'(SETTLE);
  localparam logic [STW-1:0] STALL_L  = STW'(STALL_CYCLES);
  localparam logic [STW-1:0] STALL_ONE = STW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     settle_cnt_q, settle_cnt_d;
  logic [STW-1:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]     sel_prev_q;
  logic [19:0]    digits_q, digits_d;
  logic [4:0]     dp_q, dp_d;
  logic [4:0]     valid_q, valid_d;
  logic [4:0]     seen_q, seen_d;
  logic           frame_done_q;
  logic           sel_err_q, sel_err_d;
  logic           seg_err_q, seg_err_d;

  logic       sel_onehot;
  logic       sel_bad;
  logic       sel_chg;
  logic       capture;
  logic       frame_hit;
  logic [3:0] dec_code;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] code;
    case (seg)
      7'h3F:   code = 4'h0;
      7'h06:   code = 4'h1;
      7'h5B:   code = 4'h2;
      7'h4F:   code = 4'h3;
      7'h66:   code = 4'h4;
      7'h6D:   code = 4'h5;
      7'h7D:   code = 4'h6;
      7'h07:   code = 4'h7;
      7'h7F:   code = 4'h8;
      7'h6F:   code = 4'h9;
      7'h00:   code = 4'hA;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

  assign sel_onehot = $onehot(sev_sel);
  assign sel_bad    = (sev_sel != 5'd0) && !sel_onehot;
  assign sel_chg    = (sev_sel != sel_prev_q);
  assign dec_code   = seg_decode(sev_data[6:0]);
  assign frame_hit  = (seen_q == 5'h1F);

  // Zero (blanking) and malformed selects both park the FSM; only malformed ones are errors.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    if (!sel_onehot) begin
      state_d      = S_IDLE;
      settle_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_SETTLE;
          settle_cnt_d = 4'd1;
        end
        S_SETTLE: begin
          if (sel_chg) begin
            state_d      = S_IDLE;
            settle_cnt_d = 4'd0;
          end else if (settle_cnt_q == SETTLE_L) begin
            capture      = 1'b1;
            state_d      = S_HOLD;
            settle_cnt_d = 4'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
        S_HOLD: begin
          if (sel_chg) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d      = S_IDLE;
          settle_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    seg_err_d = seg_err_q;
    sel_err_d = sel_err_q | sel_bad;
    seen_d    = frame_hit ? 5'd0 : seen_q;
    if (capture) begin
      for (int i = 0; i < 5; i++) begin
        if (sev_sel[i]) begin
          digits_d[4*i +: 4] = dec_code;
          dp_d[i]            = sev_data[7];
          valid_d[i]         = 1'b1;
        end
      end
      seen_d = seen_d | sev_sel;
      if (dec_code == 4'hF) begin
        seg_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (sel_chg) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_L) begin
      stall_cnt_d = stall_cnt_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 4'd0;
      stall_cnt_q  <= '0;
      sel_prev_q   <= 5'd0;
      digits_q     <= 20'hAAAAA;
      dp_q         <= 5'd0;
      valid_q      <= 5'd0;
      seen_q       <= 5'd0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      seg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      sel_prev_q   <= sev_sel;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_hit;
      sel_err_q    <= sel_err_d;
      seg_err_q    <= seg_err_d;
    end
  end

`ifdef SEV_SCAN_MON_FRAMECNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (frame_hit) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'd0;
`endif

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign sel_error   = sel_err_q;
  assign seg_error   = seg_err_q;
  assign stall       = (stall_cnt_q == STALL_L);

endmodule

// File: tb/tb_sev_scan_monitor.sv
// Bench for sev_scan_monitor: directed scenarios followed by randomized select runs, checked against a run-based reference model.
module tb_sev_scan_monitor;

  localparam int SETTLE = 2;
  localparam int STALL  = 1024;

  logic        clk;
  logic        rst;
  logic [4:0]  sev_sel;
  logic [7:0]  sev_data;
  logic [19:0] digits;
  logic [4:0]  dp;
  logic [4:0]  digit_valid;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        sel_error;
  logic        seg_error;
  logic        stall;

  sev_scan_monitor #(.SETTLE(SETTLE), .STALL_CYCLES(STALL)) dut (
    .clk        (clk),
    .rst        (rst),
    .sev_sel    (sev_sel),
    .sev_data   (sev_data),
    .digits     (digits),
    .dp         (dp),
    .digit_valid(digit_valid),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .sel_error  (sel_error),
    .seg_error  (seg_error),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;

  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model state: run position tracking instead of FSM states.
  logic [19:0] m_digits;
  logic [4:0]  m_dp, m_valid, m_seen, m_last;
  logic        m_fd, m_selerr, m_segerr, m_stall, m_idle;
  int          m_fc, m_run_j, m_run_d, m_held;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) begin
      if (seg_tbl[k] == p) return 4'(k);
    end
    if (p == 7'h00) return 4'hA;
    return 4'hF;
  endfunction

  function automatic bit is_onehot(input logic [4:0] s);
    return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
  endfunction

  function automatic int exp_fc();
`ifdef SEV_SCAN_MON_FRAMECNT_EN
    return m_fc;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_digits = 20'hAAAAA;
    m_dp = 5'd0; m_valid = 5'd0; m_seen = 5'd0; m_last = 5'd0;
    m_fd = 1'b0; m_selerr = 1'b0; m_segerr = 1'b0; m_stall = 1'b0;
    m_idle = 1'b1; m_fc = 0; m_run_j = 0; m_run_d = 0; m_held = 0;
  endtask

  // A one-hot run captures on its (d+SETTLE)-th edge, where d=1 if the monitor was busy when the run began.
  task automatic model_edge(input logic [4:0] s, input logic [7:0] d);
    bit         oh;
    bit         cap;
    int         idx;
    logic [3:0] code;
    oh = is_onehot(s);
    if (s != m_last) begin
      m_run_j = 0;
      m_run_d = m_idle ? 0 : 1;
      m_held  = 0;
    end else begin
      m_run_j++;
      if (m_held < STALL) m_held++;
    end
    cap  = oh && (m_run_j == m_run_d + SETTLE);
    m_fd = (m_seen == 5'h1F);
    if (m_fd) begin
      m_seen = 5'd0;
      m_fc   = (m_fc + 1) % 256;
    end
    if (s != 5'd0 && !oh) m_selerr = 1'b1;
    if (cap) begin
      idx = 0;
      for (int k = 0; k < 5; k++) if (s[k]) idx = k;
      code = ref_decode(d[6:0]);
      m_digits[4*idx +: 4] = code;
      m_dp[idx]    = d[7];
      m_valid[idx] = 1'b1;
      m_seen[idx]  = 1'b1;
      if (code == 4'hF) m_segerr = 1'b1;
    end
    m_idle  = !(oh && m_run_j >= m_run_d);
    m_last  = s;
    m_stall = (m_held == STALL);
  endtask

  task automatic check_all();
    chk("digits", 32'(digits), 32'(m_digits));
    chk("dp", 32'(dp), 32'(m_dp));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("frame_count", 32'(frame_count), 32'(exp_fc()));
    chk("sel_error", 32'(sel_error), 32'(m_selerr));
    chk("seg_error", 32'(seg_error), 32'(m_segerr));
    chk("stall", 32'(stall), 32'(m_stall));
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic [4:0] s, input logic [7:0] d);
    sev_sel  = s;
    sev_data = d;
    @(posedge clk);
    #1;
    model_edge(s, d);
    if (frame_done === 1'b1) fd_seen++;
    check_all();
    @(negedge clk);
  endtask

  task automatic run(input logic [4:0] s, input logic [7:0] d, input int n);
    for (int k = 0; k < n; k++) step(s, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic scan_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [7:0] d4);
    run(5'b00001, d0, 4);
    run(5'b00010, d1, 4);
    run(5'b00100, d2, 4);
    run(5'b01000, d3, 4);
    run(5'b10000, d4, 4);
  endtask

  initial begin
    logic [4:0] rs;
    logic [7:0] rd;
    int         pick;
    rst      = 1'b0;
    sev_sel  = 5'd0;
    sev_data = 8'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single digit capture latency
    step(5'b00001, 8'h06);
    step(5'b00001, 8'h06);
    chk("r022_not_yet", 32'(digits[3:0]), 32'hA);
    step(5'b00001, 8'h06);
    chk("r022_digit0", 32'(digits[3:0]), 32'h1);
    step(5'b00001, 8'h06);
    chk("r022_valid", 32'(digit_valid), 32'h01);
    chk("r022_errors", 32'({sel_error, seg_error}), 32'h0);

    // Full scan with dp on digit 4
    run(5'b00000, 8'h00, 2);
    fd_seen = 0;
    scan_frame(8'h3F, 8'h5B, 8'h4F, 8'h66, 8'hED);
    run(5'b00000, 8'h00, 2);
    chk("r023_digits", 32'(digits), 32'h54320);
    chk("r023_dp", 32'(dp), 32'h10);
    chk("r023_pulses", 32'(fd_seen), 32'd1);
`ifdef SEV_SCAN_MON_FRAMECNT_EN
    chk("r023_fcount", 32'(frame_count), 32'd1);
`else
    chk("r023_fcount", 32'(frame_count), 32'd0);
`endif

    // Select held too briefly
    step(5'b00100, 8'h7F);
    run(5'b00000, 8'h00, 3);
    chk("r024_valid", 32'(digit_valid), 32'h1F);
    chk("r024_digit2", 32'(digits[11:8]), 32'h3);

    // Malformed select, then an undecodable pattern
    run(5'b00110, 8'h3F, 2);
    chk("r025_selerr", 32'(sel_error), 32'h1);
    run(5'b00000, 8'h00, 2);
    run(5'b00010, 8'h49, 4);
    chk("r025_digit1", 32'(digits[7:4]), 32'hF);
    chk("r025_segerr", 32'(seg_error), 32'h1);
    chk("r025_selerr_sticky", 32'(sel_error), 32'h1);

    // Stall detection
    run(5'b01000, 8'h66, STALL);
    chk("r026_stall_before", 32'(stall), 32'h0);
    step(5'b01000, 8'h66);
    chk("r026_stall_set", 32'(stall), 32'h1);
    step(5'b00000, 8'h00);
    chk("r026_stall_clear", 32'(stall), 32'h0);

    // Reset mid-frame and mid-settle
    do_reset();
    run(5'b00000, 8'h00, 1);
    run(5'b00001, 8'h06, 4);
    run(5'b00010, 8'h5B, 4);
    run(5'b00100, 8'h4F, 4);
    run(5'b01000, 8'h7F, 2);
    do_reset();
    chk("r027_digits", 32'(digits), 32'hAAAAA);
    chk("r027_valid", 32'(digit_valid), 32'h0);
    chk("r027_fcount", 32'(frame_count), 32'h0);
    run(5'b01000, 8'h7F, 4);
    chk("r018_discarded_then_new", 32'(digits[15:12]), 32'h8);
    scan_frame(8'h7D, 8'h07, 8'h6F, 8'h00, 8'hBF);
    step(5'b00000, 8'h00);
`ifdef SEV_SCAN_MON_FRAMECNT_EN
    chk("r027_fcount_after", 32'(frame_count), 32'd1);
`else
    chk("r027_fcount_after", 32'(frame_count), 32'd0);
`endif

    // Randomized select runs
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end
      do begin
        pick = int'($urandom_range(0, 99));
        if (pick < 65) begin
          rs = 5'b00001 << $urandom_range(0, 4);
        end else if (pick < 82) begin
          rs = 5'd0;
        end else begin
          do rs = 5'($urandom_range(1, 31)); while (is_onehot(rs));
        end
      end while (rs == m_last);
      if ($urandom_range(0, 9) < 8) begin
        rd = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 9)]};
      end else begin
        rd = 8'($urandom_range(0, 255));
      end
      run(rs, rd, int'($urandom_range(1, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
